// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, owner encoding, access sizes.
// The size encoding matches the one used by the data memory.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic owner_t state_owner(input arb_state_t st);
        return (st == BUSY_D) ? OWN_D : OWN_IF;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision for the arbiter: D has priority unless IF has lost STARVE_MAX
// contested arbitrations in a row.
module mem_arb_prio
    import riscv_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic idle,
    output logic grant_if,
    output logic grant_d
);

    logic [3:0] r_starve;
    logic       w_starved;

    assign w_starved = (r_starve == 4'(STARVE_MAX));
    assign grant_if  = idle & if_req & (~d_req | w_starved);
    assign grant_d   = idle & d_req & ~grant_if;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (grant_if) begin
            r_starve <= '0;
        end else if (grant_d && if_req && !w_starved) begin
            r_starve <= r_starve + 4'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port unified memory arbiter between fetch (IF) and load/store (D).
// Optional busy watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    arb_state_t        r_state;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [1:0]        r_mem_size;
    logic              r_if_rvalid;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_idle;
    logic              w_busy;
    logic              w_grant_if;
    logic              w_grant_d;
    logic              w_timeout;

    assign w_idle = (r_state == IDLE);
    assign w_busy = ~w_idle;

    mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .d_req    (d_req),
        .idle     (w_idle),
        .grant_if (w_grant_if),
        .grant_d  (w_grant_d)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] r_tmr;
    logic          r_err;

    // Down-counter loaded on grant; terminal count on the TIMEOUT-th busy cycle.
    assign w_timeout = w_busy & ~mem_ready & (r_tmr == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmr <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_grant_if || w_grant_d) begin
                r_tmr <= TW'(TIMEOUT - 1);
            end else if (w_busy && !mem_ready && r_tmr != '0) begin
                r_tmr <= r_tmr - 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_size  <= SZ_BYTE;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_if) begin
                        r_state     <= BUSY_I;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_mem_size  <= SZ_WORD;
                    end else if (w_grant_d) begin
                        r_state     <= BUSY_D;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_size  <= d_size;
                    end
                end
                default: begin
                    if (mem_ready || w_timeout) begin
                        r_state  <= IDLE;
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        // A timed-out access still answers, with zero data.
                        if (state_owner(r_state) == OWN_IF) begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= mem_ready ? mem_rdata : '0;
                        end else begin
                            r_d_rvalid <= 1'b1;
                            if (!mem_ready) begin
                                r_d_rdata <= '0;
                            end else if (!r_mem_we) begin
                                r_d_rdata <= mem_rdata;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign if_gnt    = w_grant_if;
    assign d_gnt     = w_grant_d;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_size  = r_mem_size;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1ns after the rising edge, outputs are
// sampled 2ns after it. Timeout checks apply when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [1:0]  d_size;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge (input drive point).
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Sample point for the current cycle.
    task automatic smp();
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, err, mem_size}, '0);
        chk({tag, "_data"}, {if_rdata, d_rdata}, '0);
        chk({tag, "_mem"}, {mem_addr, mem_wdata}, '0);
    endtask

    logic [9:0] exp_order;
    logic [9:0] got_order;
    bit         seen;

    initial begin
        rst = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
        d_wdata = '0; d_size = 2'b00; mem_rdata = '0; mem_ready = 0;
        repeat (2) @(posedge clk);
        #2;
        chk_all_zero("reset");
        #1;
        rst = 1'b1;
        next();

        // Fetch alone, ready on 2nd busy cycle
        if_req = 1; if_addr = 32'h100;
        smp();
        chk("f_gnt", {if_gnt, d_gnt}, 2'b10);
        next();
        if_req = 0; if_addr = 32'h0;
        smp();
        chk("f_busy1", {if_gnt, mem_en, mem_we, mem_size}, 5'b0_1_0_10);
        chk("f_addr", mem_addr, 32'h100);
        next();
        mem_ready = 1; mem_rdata = 32'h00500093;
        smp();
        chk("f_busy2_en", {mem_en, if_rvalid}, 2'b10);
        next();
        mem_ready = 0; mem_rdata = '0;
        smp();
        chk("f_rvalid", {if_rvalid, d_rvalid, mem_en}, 3'b100);
        chk("f_rdata", if_rdata, 32'h00500093);
        next();
        smp();
        chk("f_rvalid_pulse", if_rvalid, 1'b0);

        // Store then load at 0x40
        next();
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_size = 2'b10;
        smp();
        chk("st_gnt", {if_gnt, d_gnt}, 2'b01);
        next();
        d_req = 0; d_we = 0; d_wdata = '0; mem_ready = 1; mem_rdata = 32'h12345678;
        smp();
        chk("st_busy", {mem_en, mem_we, mem_size}, 4'b1_1_10);
        chk("st_wdata", {mem_addr, mem_wdata}, {32'h40, 32'hDEADBEEF});
        next();
        mem_ready = 0;
        d_req = 1; d_we = 0; d_addr = 32'h40; d_size = 2'b10;
        smp();
        chk("st_rvalid", {d_rvalid, mem_we, d_gnt}, 3'b101);
        chk("st_rdata_kept", d_rdata, 32'h0);
        next();
        d_req = 0; mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        smp();
        chk("ld_busy", {mem_en, mem_we}, 2'b10);
        next();
        mem_ready = 0; mem_rdata = '0;
        smp();
        chk("ld_rvalid", d_rvalid, 1'b1);
        chk("ld_rdata", d_rdata, 32'hDEADBEEF);

        // Contention with immediate ready: D,D,D,D,IF,D,D,D,D,IF
        next();
        exp_order = 10'b10000_10000;
        got_order = '0;
        if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h80; mem_ready = 1;
        for (int k = 0; k < 10; k++) begin
            seen = 0;
            for (int c = 0; c < 4 && !seen; c++) begin
                smp();
                if (if_gnt || d_gnt) begin
                    seen = 1;
                    got_order[k] = if_gnt;
                    chk("ct_excl", if_gnt & d_gnt, 1'b0);
                end
                next();
            end
            if (!seen) chk("ct_timeout", 1'b0, 1'b1);
        end
        if_req = 0; d_req = 0;
        chk("ct_order", got_order, exp_order);
        next();
        mem_ready = 0;
        next();

        // Back-to-back: d_gnt on the if_rvalid cycle
        if_req = 1; if_addr = 32'h300;
        smp();
        chk("bb_ifgnt", if_gnt, 1'b1);
        next();
        if_req = 0; mem_ready = 1; mem_rdata = 32'h11;
        next();
        mem_ready = 0; d_req = 1; d_we = 0; d_addr = 32'h44;
        smp();
        chk("bb_same_cycle", {if_rvalid, if_gnt, d_gnt, d_rvalid}, 4'b1010);
        next();
        d_req = 0; mem_ready = 1; mem_rdata = 32'h22;
        smp();
        chk("bb_busy_d", {mem_en, mem_addr}, {1'b1, 32'h44});
        next();
        mem_ready = 0;
        smp();
        chk("bb_drvalid", {d_rvalid, if_rvalid, d_rdata}, {2'b10, 32'h22});

        // Reset in the middle of a store
        next();
        d_req = 1; d_we = 1; d_addr = 32'h48; d_wdata = 32'hA5A5A5A5;
        next();
        d_req = 0; d_we = 0;
        smp();
        chk("rm_busy", {mem_en, mem_we}, 2'b11);
        #2;
        rst = 0;
        #1;
        chk_all_zero("rm_async");
        next();
        rst = 1; mem_ready = 1; mem_rdata = 32'h77;
        for (int c = 0; c < 3; c++) begin
            smp();
            chk("rm_no_rvalid", {d_rvalid, if_rvalid, mem_en, d_rdata}, '0);
            next();
        end
        mem_ready = 0;

        // Long stall: watchdog fires after 16 busy cycles when enabled
        d_req = 1; d_we = 0; d_addr = 32'h4C;
        next();
        d_req = 0; mem_ready = 1; mem_rdata = 32'h5A5A;
        next();
        mem_ready = 0;
        smp();
        chk("pre_ld", d_rdata, 32'h5A5A);
        next();
        d_req = 1; d_addr = 32'h50;
        smp();
        chk("to_gnt", d_gnt, 1'b1);
        next();
        d_req = 0;
        for (int c = 1; c <= 16; c++) begin
            smp();
            if (c == 1 || c == 16) chk("to_busy", {mem_en, d_rvalid, err}, 3'b100);
            next();
        end
        smp();
`ifdef MEM_ARB_TIMEOUT_EN
        chk("to_fire", {d_rvalid, mem_en, err}, 3'b101);
        chk("to_rdata", d_rdata, 32'h0);
        repeat (3) next();
        smp();
        chk("to_sticky", {err, d_rvalid}, 2'b10);
`else
        chk("no_to_wait", {d_rvalid, mem_en, err}, 3'b010);
        repeat (4) next();
        mem_ready = 1; mem_rdata = 32'h99;
        next();
        mem_ready = 0;
        smp();
        chk("no_to_done", {d_rvalid, err, d_rdata}, {2'b10, 32'h99});
`endif

        next();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=hang exp=finish");
        $fatal(1);
    end

endmodule
